// File: rtl/mram_arb_pkg.sv
// Shared types for the MRAM port arbiter: FSM states, owner encodings and
// the {NVR,TMEN,AREF} mode bundle.
package mram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_OWN = 2'd1,
    WR_OWN = 2'd2
  } arb_state_e;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef struct packed {
    logic nvr;
    logic tmen;
    logic aref;
  } mram_mode_t;

endpackage

// File: rtl/mram_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins; on a tie the path that
// did not own the port last time wins.
module mram_arb_rr_pick
  import mram_arb_pkg::*;
(
  input  logic rd_req_i,
  input  logic wr_req_i,
  input  logic last_owner_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o  = rd_req_i | wr_req_i;
    winner_o = RD;
    if (rd_req_i && wr_req_i) begin
      winner_o = ~last_owner_i;
    end else if (wr_req_i) begin
      winner_o = WR;
    end
  end

endmodule

// File: rtl/mram_access_arbiter.sv
// Arbitrates the single MRAM macro port between the uDMA read and write size
// converters with round-robin priority, transaction locking and burst limit.
//
// state  | meaning
// IDLE   | no owner; winner of the round-robin pick is served combinationally
// RD_OWN | read path holds the port until rd_eot_i or a burst yield
// WR_OWN | write path holds the port until wr_eot_i or a burst yield
module mram_access_arbiter
  import mram_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 0,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_clk_en_i,
  input  logic              rd_eot_i,
  input  logic [2:0]        rd_mode_i,
  output logic              rd_gnt_o,
  output logic [DATA_W-1:0] rd_rdata_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_wdata_i,
  input  logic              wr_clk_en_i,
  input  logic              wr_eot_i,
  input  logic [2:0]        wr_mode_i,
  output logic              wr_gnt_o,
  output logic              mram_req_o,
  output logic              mram_we_o,
  output logic [ADDR_W-1:0] mram_addr_o,
  output logic [DATA_W-1:0] mram_wdata_o,
  output logic              mram_clk_en_o,
  output logic [2:0]        mram_mode_o,
  input  logic              mram_gnt_i,
  input  logic [DATA_W-1:0] mram_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  arb_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  mram_mode_t        mode_q, mode_d;

  logic pick_valid, pick_winner;
  logic sel_valid, sel_wr, sel_req, sel_eot, peer_req;
  logic in_own, burst_hit, yield, eot_block;
  logic port_req, path_gnt, beat;

  mram_arb_rr_pick u_rr_pick (
    .rd_req_i     (rd_req_i),
    .wr_req_i     (wr_req_i),
    .last_owner_i (last_owner_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_wr    = RD;
    case (state_q)
      IDLE: begin
        sel_valid = pick_valid;
        sel_wr    = pick_winner;
      end
      RD_OWN: begin
        sel_valid = 1'b1;
        sel_wr    = RD;
      end
      WR_OWN: begin
        sel_valid = 1'b1;
        sel_wr    = WR;
      end
      default: begin
        sel_valid = 1'b0;
        sel_wr    = RD;
      end
    endcase

    sel_req   = sel_wr ? wr_req_i : rd_req_i;
    sel_eot   = sel_wr ? wr_eot_i : rd_eot_i;
    peer_req  = sel_wr ? rd_req_i : wr_req_i;
    in_own    = (state_q != IDLE);
    burst_hit = (MAX_BURST != 0) && (beat_cnt_q >= CNT_W'(MAX_BURST));
    yield     = in_own & burst_hit & peer_req;
    // eot closes the transaction; a request in that same cycle is refused
    eot_block = in_own & sel_eot;

    port_req = rst_n & sel_valid & sel_req & ~yield & ~eot_block;
    path_gnt = rst_n & sel_valid & mram_gnt_i & ~yield & ~eot_block;
    beat     = sel_req & path_gnt;

    mram_req_o    = port_req;
    rd_gnt_o      = path_gnt & (sel_wr == RD);
    wr_gnt_o      = path_gnt & (sel_wr == WR);
    mram_addr_o   = sel_valid ? (sel_wr ? wr_addr_i : rd_addr_i) : '0;
    mram_we_o     = port_req & (sel_wr == WR);
    mram_wdata_o  = mram_we_o ? wr_wdata_i : '0;
    mram_clk_en_o = path_gnt & (sel_wr ? wr_clk_en_i : rd_clk_en_i);
    mram_mode_o   = mode_q;
    rd_rdata_o    = mram_rdata_i;
    busy_o        = in_own;
    owner_o       = (state_q == WR_OWN);

    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    mode_d       = mode_q;
    case (state_q)
      IDLE: begin
        if (pick_valid && beat) begin
          state_d      = pick_winner ? WR_OWN : RD_OWN;
          last_owner_d = pick_winner;
          mode_d       = mram_mode_t'(pick_winner ? wr_mode_i : rd_mode_i);
          beat_cnt_d   = CNT_W'(1);
        end
      end
      RD_OWN, WR_OWN: begin
        if (sel_eot || yield) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end else if (beat && (beat_cnt_q != '1)) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= WR;
      beat_cnt_q   <= '0;
      mode_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      mode_q       <= mode_d;
    end
  end

endmodule
